// File: rtl/fifo_rd_streamer_pkg.sv
// Shared constants for the FIFO read-side streamer: default widths, packet length
// and the read latency of the upstream asynchronous_fifo.
package fifo_rd_streamer_pkg;

   localparam int unsigned DATA_WIDTH_DEF  = 8;
   localparam int unsigned SKID_DEPTH_DEF  = 3;
   localparam int unsigned PKT_LEN_DEF     = 4;
   localparam int unsigned CNT_WIDTH_DEF   = 16;
   // Cycles from a posedge with r_en=1 until data_out holds the popped word.
   localparam int unsigned FIFO_RD_LATENCY = 1;

   // Minimum-one-bit index width for a counter/pointer covering n values.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus valid/ready output stream of fifo_rd_streamer.
// master = the streamer, slave = FIFO/consumer side.
interface fifo_rd_streamer_if
   import fifo_rd_streamer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_r_en;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;
   logic [CNT_WIDTH-1:0]  word_cnt;
   logic                  busy;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_r_en, m_data, m_valid, m_last, word_cnt, busy
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_r_en, m_data, m_valid, m_last, word_cnt, busy
   );
endinterface

// File: rtl/fifo_rd_streamer_skid_buffer.sv
// Circular DEPTH-entry store with push/pop and occupancy; head entry is always
// visible on head_data.
module fifo_rd_streamer_skid_buffer
   import fifo_rd_streamer_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter  int unsigned DEPTH      = SKID_DEPTH_DEF,
   localparam int unsigned PTR_W      = idx_width(DEPTH),
   localparam int unsigned OCC_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [OCC_W-1:0]      occ
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage is cleared on reset so the head word reads zero while empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= ptr_inc(tail);
         end
         if (pop) begin
            head <= ptr_inc(head);
         end
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-domain streamer: pops asynchronous_fifo words into a skid buffer and
// presents them as a framed valid/ready stream with a running word count.
module fifo_rd_streamer
   import fifo_rd_streamer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF,
   parameter int unsigned PKT_LEN    = PKT_LEN_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input logic                rclk,
   input logic                rrst,
   fifo_rd_streamer_if.master bus
);

   localparam int unsigned OCC_W  = $clog2(SKID_DEPTH + 1);
   localparam int unsigned FILL_W = OCC_W + 1;
   localparam int unsigned BEAT_W = idx_width(PKT_LEN);

   logic                  inflight;
   logic [OCC_W-1:0]      occ;
   logic [FILL_W-1:0]     fill;
   logic                  fifo_r_en_c;
   logic                  has_data_c;
   logic                  pop_c;
   logic [DATA_WIDTH-1:0] head_data;
   logic [BEAT_W-1:0]     beat;
   logic [CNT_WIDTH-1:0]  word_cnt_q;

   // Reserve a slot for every word already read, so the buffer can never overflow.
   assign fill        = FILL_W'(occ) + FILL_W'(inflight);
   assign fifo_r_en_c = !bus.fifo_empty && (fill < FILL_W'(SKID_DEPTH));
   assign has_data_c  = (occ != '0);
   assign pop_c       = has_data_c && bus.m_ready;

   // FIFO data_out is valid one cycle after the read, so a single flag tracks it.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_r_en_c;
      end
   end

   fifo_rd_streamer_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SKID_DEPTH)
   ) u_skid (
      .clk       (rclk),
      .rst       (rrst),
      .push      (inflight),
      .push_data (bus.fifo_data),
      .pop       (pop_c),
      .head_data (head_data),
      .occ       (occ)
   );

   // Packet position and accepted-word count both advance on consumer accept.
   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         beat       <= '0;
         word_cnt_q <= '0;
      end else if (pop_c) begin
         beat       <= (beat == BEAT_W'(PKT_LEN - 1)) ? '0 : beat + 1'b1;
         word_cnt_q <= word_cnt_q + 1'b1;
      end
   end

   assign bus.fifo_r_en = fifo_r_en_c;
   assign bus.m_valid   = has_data_c;
   assign bus.m_data    = head_data;
   assign bus.m_last    = has_data_c && (beat == BEAT_W'(PKT_LEN - 1));
   assign bus.word_cnt  = word_cnt_q;
   assign bus.busy      = has_data_c || inflight;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench for fifo_rd_streamer: queue-based FIFO model, expected-word
// queue and a negedge monitor checking the stream against word-level bookkeeping.
module tb_fifo_rd_streamer;
   import fifo_rd_streamer_pkg::*;

   localparam int unsigned DW   = 8;
   localparam int unsigned SD   = 3;
   localparam int unsigned PL   = 4;
   localparam int unsigned CW   = 16;
   localparam int unsigned CW_S = 4;

   logic rclk = 1'b0;
   logic rrst = 1'b0;
   always #5 rclk = ~rclk;

   fifo_rd_streamer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW))   bus ();
   fifo_rd_streamer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW_S)) bus_s ();

   fifo_rd_streamer #(.DATA_WIDTH(DW), .SKID_DEPTH(SD), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
      .rclk (rclk), .rrst (rrst), .bus (bus)
   );
   // Same stream into a narrow-counter instance to observe word_cnt wrap.
   fifo_rd_streamer #(.DATA_WIDTH(DW), .SKID_DEPTH(SD), .PKT_LEN(PL), .CNT_WIDTH(CW_S)) dut_s (
      .rclk (rclk), .rrst (rrst), .bus (bus_s)
   );
   assign bus_s.fifo_empty = bus.fifo_empty;
   assign bus_s.fifo_data  = bus.fifo_data;
   assign bus_s.m_ready    = bus.m_ready;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] in_q[$];
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int unsigned   popped;
   int unsigned   accepted;
   int unsigned   outst;
   logic          prev_stall;
   logic [DW-1:0] prev_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // FIFO model: one-cycle read latency, writes become visible after the next edge.
   always @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         fifo_q.delete();
         in_q.delete();
         bus.fifo_empty <= 1'b1;
         bus.fifo_data  <= '0;
      end else begin
         if (bus.fifo_r_en && !bus.fifo_empty) bus.fifo_data <= fifo_q.pop_front();
         while (in_q.size() > 0) fifo_q.push_back(in_q.pop_front());
         bus.fifo_empty <= (fifo_q.size() == 0);
      end
   end

   // Monitor: words read but not yet accepted must all be held inside the streamer.
   always @(negedge rclk) begin
      if (rrst) begin
         popped     = 0;
         accepted   = 0;
         prev_stall = 1'b0;
      end else begin
         outst = popped - accepted;
         chk("busy", 32'(bus.busy), 32'(outst != 0));
         chk("fifo_r_en", 32'(bus.fifo_r_en), 32'(!bus.fifo_empty && (outst < SD)));
         chk("occ_bound", 32'(outst <= SD), 32'd1);
         chk("word_cnt", 32'(bus.word_cnt), 32'(CW'(accepted)));
         chk("word_cnt_narrow", 32'(bus_s.word_cnt), 32'(CW_S'(accepted)));
         chk("m_last", 32'(bus.m_last), 32'(bus.m_valid && ((accepted % PL) == PL - 1)));
         if (prev_stall) begin
            chk("hold_valid", 32'(bus.m_valid), 32'd1);
            chk("hold_data", 32'(bus.m_data), 32'(prev_data));
         end
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word actual=%0h required=none t=%0t", bus.m_data, $time);
            end else begin
               chk("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
            end
            accepted++;
         end
         if (bus.fifo_r_en) popped++;
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
      end
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      in_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_r_en"}, 32'(bus.fifo_r_en), 32'd0);
      chk({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
      chk({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
      chk({tag, "_m_last"}, 32'(bus.m_last), 32'd0);
      chk({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_word_cnt_narrow"}, 32'(bus_s.word_cnt), 32'd0);
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int n = 0;
      while (!(in_q.size() == 0 && fifo_q.size() == 0 && !bus.busy) && n < max_cyc) begin
         tick();
         n++;
      end
      chk({tag, "_idle_timeout"}, 32'(n < max_cyc), 32'd1);
      chk({tag, "_exp_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int fr, lr, rn, fv, lv, vn, nv;
      logic [DW-1:0] lasts[$];
      logic [DW-1:0] seen;

      bus.m_ready = 1'b0;
      #1 rrst = 1'b1;
      #1 check_zero("reset");
      exp_q.delete();
      tick();
      tick();
      rrst = 1'b0;
      tick();

      // Continuous stream of 0..7.
      bus.m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push_word(DW'(i));
      fr = -1; lr = -1; rn = 0; fv = -1; lv = -1; vn = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge rclk);
         if (bus.fifo_r_en) begin if (fr < 0) fr = c; lr = c; rn++; end
         if (bus.m_valid)   begin if (fv < 0) fv = c; lv = c; vn++; end
      end
      tick();
      chk("stream_ren_count", 32'(rn), 32'd8);
      chk("stream_ren_span", 32'(lr - fr), 32'd7);
      chk("stream_valid_count", 32'(vn), 32'd8);
      chk("stream_valid_span", 32'(lv - fv), 32'd7);
      chk("stream_latency", 32'(fv - fr), 32'd2);
      wait_idle("stream", 40);
      chk("stream_word_cnt", 32'(bus.word_cnt), 32'd8);

      // Back-pressure: buffer fills to SKID_DEPTH, head held.
      bus.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(DW'(8'h20 + i));
      rn = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge rclk);
         if (bus.fifo_r_en) rn++;
      end
      chk("bp_ren_count", 32'(rn), 32'(SD));
      chk("bp_valid", 32'(bus.m_valid), 32'd1);
      chk("bp_head", 32'(bus.m_data), 32'h20);
      tick();
      bus.m_ready = 1'b1;
      wait_idle("bp", 40);
      chk("bp_word_cnt", 32'(bus.word_cnt), 32'd16);

      // Intermittent ready over words 100..109.
      for (int i = 0; i < 10; i++) push_word(DW'(100 + i));
      for (int c = 0; c < 40; c++) begin
         @(negedge rclk);
         if (bus.m_valid && bus.m_ready && bus.m_last) lasts.push_back(bus.m_data);
         tick();
         bus.m_ready = ~bus.m_ready;
      end
      bus.m_ready = 1'b1;
      wait_idle("toggle", 40);
      chk("toggle_last_count", 32'(lasts.size()), 32'd2);
      if (lasts.size() == 2) begin
         chk("toggle_last0", 32'(lasts[0]), 32'd103);
         chk("toggle_last1", 32'(lasts[1]), 32'd107);
      end

      // Single word across the empty boundary.
      push_word(8'h55);
      rn = 0; vn = 0; seen = '0;
      for (int c = 0; c < 8; c++) begin
         @(negedge rclk);
         if (bus.fifo_r_en) rn++;
         if (bus.m_valid) begin vn++; seen = bus.m_data; end
      end
      tick();
      chk("single_ren", 32'(rn), 32'd1);
      chk("single_beats", 32'(vn), 32'd1);
      chk("single_data", 32'(seen), 32'h55);
      chk("single_word_cnt", 32'(bus.word_cnt), 32'd27);

      // Random pushes and ready.
      for (int c = 0; c < 400; c++) begin
         bus.m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) push_word(DW'($urandom));
         end
         tick();
      end
      bus.m_ready = 1'b1;
      wait_idle("random", 200);

      // Reset with two words buffered and one in flight.
      bus.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(DW'(8'h30 + i));
      for (int c = 0; c < 4; c++) tick();
      chk("pre_reset_outstanding", 32'(popped - accepted), 32'd3);
      #1 rrst = 1'b1;
      #1 check_zero("midreset");
      exp_q.delete();
      tick();
      tick();
      rrst = 1'b0;
      bus.m_ready = 1'b1;
      nv = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge rclk);
         if (bus.m_valid) nv++;
      end
      tick();
      chk("post_reset_silent", 32'(nv), 32'd0);

      // 17 words after reset: packet framing restarts, narrow counter wraps to 1.
      lasts.delete();
      for (int i = 0; i < 17; i++) push_word(DW'(8'h40 + i));
      for (int c = 0; c < 30; c++) begin
         @(negedge rclk);
         if (bus.m_valid && bus.m_ready && bus.m_last) lasts.push_back(bus.m_data);
         tick();
      end
      wait_idle("wrap", 40);
      chk("wrap_first_last", 32'(lasts.size() > 0 ? lasts[0] : 8'h00), 32'h43);
      chk("wrap_word_cnt", 32'(bus.word_cnt), 32'd17);
      chk("wrap_word_cnt_narrow", 32'(bus_s.word_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
